sram_mem_controller: RTL and testbench

//  MEM-stage data-memory controller for the 5-stage ARM pipeline. Turns one 32-bit load/store

---
 rtl/sram_mem_controller.sv | 168 ++++++++++++++++
 tb/tb_sram_mem_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage bridge that turns one 32-bit load/store into
// two timed half-word accesses on an external 16-bit asynchronous SRAM.
// ready drops while an access is in flight; the top level freezes on ~ready.
// Optional feature: define SRAM_RD_BUF_EN for a one-entry read buffer that
// answers a repeated load of the same address without touching the SRAM.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t             state;
  state_t             next_state;
  logic [3:0]         cnt;
  logic               last;
  logic               start;
  logic               hit;
  logic               lat_wr;
  logic [31:0]        lat_wdata;
  logic [31:0]        rdata_q;
  logic [31:0]        eff;
  logic [SRAM_AW-2:0] eff_idx;
  logic               unused_eff;
  logic               dq_oe;
  logic [15:0]        dq_out;

  // The SRAM is permanently selected with both byte lanes enabled
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // Address bits above the SRAM size wrap; the byte offset within a word is dropped
  assign eff        = address - 32'(BASE_ADDR);
  assign eff_idx    = eff[SRAM_AW:2];
  assign unused_eff = ^{eff[31:SRAM_AW+1], eff[1:0]};

  assign last = (cnt == LAST_CNT);

`ifdef SRAM_RD_BUF_EN
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic [31:0] lat_addr;

  assign hit = (state == IDLE) & rd_en & ~wr_en & buf_valid & (address == buf_addr);

  // Read buffer: filled by every completed read, dropped by any accepted write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      lat_addr  <= '0;
    end else begin
      if (start) lat_addr <= address;
      if ((state == IDLE) && wr_en) begin
        buf_valid <= 1'b0;
      end else if ((state == HI) && last && !lat_wr) begin
        buf_valid <= 1'b1;
        buf_addr  <= lat_addr;
        buf_data  <= {SRAM_DQ, rdata_q[15:0]};
      end
    end
  end

  assign rdata = hit ? buf_data : rdata_q;
`else
  assign hit   = 1'b0;
  assign rdata = rdata_q;
`endif

  assign start = (state == IDLE) & (rd_en | wr_en) & ~hit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state, handshake and write-strobe decode
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    SRAM_WE_N  = 1'b1;
    dq_oe      = 1'b0;
    dq_out     = lat_wdata[15:0];
    case (state)
      IDLE: begin
        ready = ~rd_en & ~wr_en | hit;
        if (start) next_state = LO;
      end
      LO: begin
        dq_oe     = lat_wr;
        SRAM_WE_N = ~(lat_wr & ~last);
        if (last) next_state = HI;
      end
      HI: begin
        dq_oe     = lat_wr;
        dq_out    = lat_wdata[31:16];
        SRAM_WE_N = ~(lat_wr & ~last);
        if (last) next_state = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

  // Per-phase wait counter, restarted at the beginning of each half-word phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if ((state == LO) || (state == HI)) begin
      cnt <= last ? 4'd0 : cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  // Request capture, SRAM address sequencing and read-data assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
      SRAM_ADDR <= '0;
      rdata_q   <= '0;
    end else begin
      if (start) begin
        lat_wr    <= wr_en;
        lat_wdata <= wdata;
        SRAM_ADDR <= {eff_idx, 1'b0};
      end
      if ((state == LO) && last) begin
        SRAM_ADDR <= {SRAM_ADDR[SRAM_AW-1:1], 1'b1};
        if (!lat_wr) rdata_q[15:0] <= SRAM_DQ;
      end
      if ((state == HI) && last && !lat_wr) begin
        rdata_q[31:16] <= SRAM_DQ;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: directed bench for sram_mem_controller with a
// behavioural 16-bit asynchronous SRAM hanging off the data bus.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n;
  logic        ub_n;
  logic        lb_n;
  logic        ce_n;
  logic        oe_n;

  logic [15:0] mem [0:255];
  logic        tb_drive;

  int          checks   = 0;
  int          failures = 0;
  int          stall;
  logic [31:0] rdata_seen;
  logic [17:0] addr_log [0:15];
  logic [15:0] dq_log   [0:15];
  logic        we_log   [0:15];

`ifdef SRAM_RD_BUF_EN
  localparam int REPEAT_STALL = 0;
`else
  localparam int REPEAT_STALL = 11;
`endif

  sram_mem_controller dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // SRAM model: drives the bus only while the bench is running a load
  assign sram_dq = tb_drive ? mem[sram_addr[7:0]] : 16'bz;

  // SRAM model write port, captured on every clock where WE_N is low
  always @(posedge clk) begin
    if (!we_n) mem[sram_addr[7:0]] <= sram_dq;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  function automatic int count_we_low(input int first, input int lastc);
    int n = 0;
    for (int k = first; k <= lastc; k++) if (we_log[k] == 1'b0) n++;
    return n;
  endfunction

  // One access: request held for the first edge only, then wait (bounded) for ready.
  // Cycle 0 is the IDLE cycle that sees the request; bus state is logged per cycle.
  task automatic apply_stimulus(input logic w, input logic r,
                                input logic [31:0] addr, input logic [31:0] data);
    int cyc;
    for (int k = 0; k < 16; k++) begin
      addr_log[k] = '0;
      dq_log[k]   = '0;
      we_log[k]   = 1'b1;
    end
    @(negedge clk);
    wr_en    = w;
    rd_en    = r;
    address  = addr;
    wdata    = data;
    tb_drive = ~w;
    #1;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #1;
      cyc++;
      if (cyc < 16) begin
        addr_log[cyc] = sram_addr;
        dq_log[cyc]   = sram_dq;
        we_log[cyc]   = we_n;
      end
    end
    stall      = cyc;
    rdata_seen = rdata;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    @(negedge clk);
    tb_drive = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    address  = '0;
    wdata    = '0;
    tb_drive = 1'b0;

    // Test 1: reset held for three cycles
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rst_we_n",   32'(we_n), 32'd1);
    check_output("rst_ready",  32'(ready), 32'd1);
    check_output("rst_rdata",  rdata, 32'h0);
    check_output("rst_addr",   32'(sram_addr), 32'd0);
    check_output("rst_ctrl",   32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);

    // Test 2: store 0x12345678 at the base address
    apply_stimulus(1'b1, 1'b0, 32'd1024, 32'h1234_5678);
    check_output("wr1_stall",    32'(stall), 32'd11);
    check_output("wr1_lo_addr",  32'(addr_log[1]), 32'd0);
    check_output("wr1_lo_dq",    32'(dq_log[1]), 32'h5678);
    check_output("wr1_lo_hold",  32'(dq_log[5]), 32'h5678);
    check_output("wr1_lo_we",    32'(count_we_low(1, 5)), 32'd4);
    check_output("wr1_lo_last",  32'(we_log[5]), 32'd1);
    check_output("wr1_hi_addr",  32'(addr_log[6]), 32'd1);
    check_output("wr1_hi_dq",    32'(dq_log[10]), 32'h1234);
    check_output("wr1_hi_we",    32'(count_we_low(6, 10)), 32'd4);
    check_output("wr1_mem",      {mem[1], mem[0]}, 32'h1234_5678);

    // Test 3: load it back
    apply_stimulus(1'b0, 1'b1, 32'd1024, 32'h0);
    check_output("rd1_stall",  32'(stall), 32'd11);
    check_output("rd1_rdata",  rdata_seen, 32'h1234_5678);
    check_output("rd1_no_we",  32'(count_we_low(1, 10)), 32'd0);

    // Test 4: store to the next word with both requests raised (store wins)
    apply_stimulus(1'b1, 1'b1, 32'd1028, 32'hDEAD_BEEF);
    check_output("wr2_stall",   32'(stall), 32'd11);
    check_output("wr2_lo_addr", 32'(addr_log[1]), 32'd2);
    check_output("wr2_lo_dq",   32'(dq_log[1]), 32'hBEEF);
    check_output("wr2_hi_addr", 32'(addr_log[6]), 32'd3);
    check_output("wr2_hi_dq",   32'(dq_log[6]), 32'hDEAD);
    check_output("wr2_we",      32'(count_we_low(1, 10)), 32'd8);
    check_output("wr2_rdata_kept", rdata_seen, 32'h1234_5678);
    check_output("wr2_addr_hold",  32'(sram_addr), 32'd3);

    apply_stimulus(1'b0, 1'b1, 32'd1028, 32'h0);
    check_output("rd2_rdata", rdata_seen, 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 1'b1, 32'd1024, 32'h0);
    check_output("rd3_rdata", rdata_seen, 32'h1234_5678);

    // Address bits above the SRAM range wrap back onto half-word 0
    apply_stimulus(1'b0, 1'b1, 32'd1024 + 32'h0008_0000, 32'h0);
    check_output("wrap_addr",  32'(addr_log[1]), 32'd0);
    check_output("wrap_stall", 32'(stall), 32'd11);
    check_output("wrap_rdata", rdata_seen, 32'h1234_5678);

    // Test 5: reset asserted in the middle of the high phase of a store
    @(negedge clk);
    wr_en   = 1'b1;
    address = 32'd1032;
    wdata   = 32'hAAAA_5555;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_output("abort_we_before", 32'(we_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    check_output("abort_we_n",  32'(we_n), 32'd1);
    check_output("abort_ready", 32'(ready), 32'd1);
    check_output("abort_addr",  32'(sram_addr), 32'd0);
    check_output("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("post_rst_ready", 32'(ready), 32'd1);
    check_output("post_rst_we_n",  32'(we_n), 32'd1);

    // Test 6: repeated load, then store and load of the same word
    apply_stimulus(1'b0, 1'b1, 32'd1024, 32'h0);
    check_output("buf_first_stall", 32'(stall), 32'd11);
    check_output("buf_first_rdata", rdata_seen, 32'h1234_5678);
    apply_stimulus(1'b0, 1'b1, 32'd1024, 32'h0);
    check_output("buf_repeat_stall", 32'(stall), 32'(REPEAT_STALL));
    check_output("buf_repeat_rdata", rdata_seen, 32'h1234_5678);
    apply_stimulus(1'b1, 1'b0, 32'd1024, 32'hCAFE_F00D);
    check_output("buf_wr_stall", 32'(stall), 32'd11);
    apply_stimulus(1'b0, 1'b1, 32'd1024, 32'h0);
    check_output("buf_after_wr_stall", 32'(stall), 32'd11);
    check_output("buf_after_wr_rdata", rdata_seen, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
